dvp_pattern_tx: RTL and testbench
=================================

# dvp_pattern_tx

Synthesizable OV5640-style DVP transmitter: it generates `camera_vsync` / `camera_href` / `camera_data` with the same framing and RGB565 byte order that the camera capture path consumes, one byte per clock. It sits in place of the sensor pins for bring-up of the capture → DDR → LCD chain without a camera, and serves as the stimulus source for capture-side regression. Four built-in test patterns are available, selected per frame.

## Interface
- `H_ACTIVE`, 480, active pixels per line; must be a multiple of 16.
- `V_ACTIVE`, 272, active lines per frame.
- `H_BLANK`, 64, `href`-low clocks after each line's data; must be ≥1.
- `VSYNC_W`, 2, lines with vsync high.
- `V_BACK`, 4, idle lines between vsync and the first active line.
- `V_FRONT`, 2, idle lines after the last active line.
- `clk`  in  1  byte clock; it also drives the downstream `camera_pclk`.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  generate frames; sampled only at frame boundaries.
- `mode`  in  2  pattern select, sampled with `en`.
- `camera_vsync`  out  1  frame sync, active high.
- `camera_href`  out  1  line valid.
- `camera_data`  out  8  RGB565 byte, high byte first.
- `frame_start`  out  1  one-cycle pulse on the first vsync-high cycle.
- `frame_cnt`  out  16  number of frames started; wraps from FFFF to 0000.
- `busy`  out  1  high while a frame is in progress.

## Operation
- The line length is `LINE_LEN = 2*H_ACTIVE + H_BLANK` clocks. Every line of every state is `LINE_LEN` clocks long.
- The horizontal counter `hcnt` runs 0..`LINE_LEN`-1. The line counter `lcnt` counts lines within the current state.
- State machine:
  - IDLE: all outputs low. If `en`=1, latch `mode` into `mode_q`, then go to VSYNC.
  - VSYNC (`VSYNC_W` lines): vsync high, href low.
  - VBACK (`V_BACK` lines): href low. A zero-length state is skipped.
  - ACTIVE (`V_ACTIVE` lines, `y` = 0..V_ACTIVE-1): href is high for `hcnt` < 2*H_ACTIVE. Pixel `x` = `hcnt`>>1. `hcnt[0]`=0 sends the high byte, `hcnt[0]`=1 sends the low byte.
  - VFRONT (`V_FRONT` lines): href low. This is the last state of the frame.
  - At the end of VFRONT: if `en`=1, latch `mode` and go directly to VSYNC (back-to-back frames, no IDLE cycle). Otherwise go to IDLE.
- Deasserting `en` or changing `mode` mid-frame has no effect until the current frame completes.
- `camera_data` is 00 whenever href is low.
- Patterns (16-bit RGB565 `pix`):
  - 0, colour bars: 8 bars, each `H_ACTIVE/8` pixels wide. Colours left to right: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - 1, grey ramp: `g` = `x[7:0]`; `pix` = {`g[7:3]`, `g[7:2]`, `g[7:3]`}.
  - 2, checkerboard: `pix` = FFFF if `x[3]` ^ `y[3]`, else 0000.
  - 3, scrolling checker: as pattern 2, but using `x' = (x + frame_cnt[7:0])` mod 256. `frame_cnt` is the value latched at frame start.
- `frame_cnt` increments on the IDLE/VFRONT→VSYNC transition. Its first frame after reset reports 1.
- `busy` = (state ≠ IDLE).

## Timing
- All outputs are registered. Each output reflects the counter/state of the previous cycle (1-cycle latency from state to pins).
- Reset (asynchronous assert, synchronous release):
  - state IDLE;
  - `camera_vsync`, `camera_href`, `camera_data`, `frame_start`, `busy` = 0;
  - `frame_cnt` = 0.
- From `en`=1 seen in IDLE at cycle N: `camera_vsync` and `frame_start` are first high at N+2, and `busy` rises at N+2.
- First href-high cycle = the vsync rise + (`VSYNC_W` + `V_BACK`)·`LINE_LEN` clocks.
- Each href pulse lasts exactly 2·`H_ACTIVE` clocks and is followed by exactly `H_BLANK` low clocks.
- Frame period = (`VSYNC_W` + `V_BACK` + `V_ACTIVE` + `V_FRONT`)·`LINE_LEN` clocks.
- Reset asserted mid-frame forces all outputs low immediately. No partial href pulse resumes after release.
- If `en` is toggled in the same cycle as the VFRONT end, the value sampled in that cycle decides.

## Structure
- Shared package `dvp_pkg` holds:
  - the state enum (IDLE, VSYNC, VBACK, ACTIVE, VFRONT);
  - the RGB565 colour constants;
  - the `mode` encodings.
- One sub-module, `dvp_pattern_gen`: a combinational function of (`mode_q`, `x`, `y`, `frame_cnt`) that returns `pix`. The top level holds the counters, the FSM and the output registers.

## Test plan
Unless noted, parameters are `H_ACTIVE`=16, `H_BLANK`=4, `V_ACTIVE`=4, `VSYNC_W`=1, `V_BACK`=1, `V_FRONT`=1.
- Reset/idle: hold `en`=0 for 100 clk → all outputs 0, `frame_cnt`=0.
- Framing, `mode`=0: `en`=1 → `frame_start` at N+2; first href after 72 clocks from the vsync rise; 4 href pulses of 32 clocks each, separated by 4 low clocks; frame period 252 clocks.
- Colour bars, `mode`=0: bytes of line 0 are FF,FF,FF,FF,FF,E0,FF,E0,07,FF,… ending 00,00; the capture model reassembles 16 pixels matching the bar table.
- Mode/enable sampling: switch `mode` 0→2 and drop `en` mid-frame 1 → frame 1 completes as bars, then IDLE with `busy`=0; `frame_cnt`=1.
- Checkerboard, `mode`=2, `H_ACTIVE`=32, `V_ACTIVE`=16: pixel (8,0)=FFFF, (0,0)=0000, (8,8)=0000; `mode`=3 in frame 2 shifts `x` by 2.
- Wrap/reset: preload `frame_cnt`=FFFF by force, run one frame → 0000. Then assert `rst_n`=0 mid-ACTIVE → href and data drop to 0 the same cycle.

Source files
------------

// File: rtl/dvp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dvp_pkg
//  Brief    : Shared types and constants for the DVP test-pattern transmitter.
//  Revision : 1.0 - initial release
// ============================================================================
package dvp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFRONT = 3'd4
    } dvp_state_t;

    localparam logic [15:0] c_white   = 16'hFFFF;
    localparam logic [15:0] c_yellow  = 16'hFFE0;
    localparam logic [15:0] c_cyan    = 16'h07FF;
    localparam logic [15:0] c_green   = 16'h07E0;
    localparam logic [15:0] c_magenta = 16'hF81F;
    localparam logic [15:0] c_red     = 16'hF800;
    localparam logic [15:0] c_blue    = 16'h001F;
    localparam logic [15:0] c_black   = 16'h0000;

    localparam logic [1:0] c_mode_bars   = 2'd0;
    localparam logic [1:0] c_mode_grey   = 2'd1;
    localparam logic [1:0] c_mode_check  = 2'd2;
    localparam logic [1:0] c_mode_scroll = 2'd3;

    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        logic [15:0] col;
        case (idx)
            3'd0:    col = c_white;
            3'd1:    col = c_yellow;
            3'd2:    col = c_cyan;
            3'd3:    col = c_green;
            3'd4:    col = c_magenta;
            3'd5:    col = c_red;
            3'd6:    col = c_blue;
            default: col = c_black;
        endcase
        return col;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dvp_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module   : dvp_pattern_gen
//  Brief    : Combinational RGB565 test-pattern source, one pixel per (x, y).
//  Revision : 1.0 - initial release
// ============================================================================
module dvp_pattern_gen
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE = 480
) (
    input  logic [1:0]  mode_q,
    input  logic [15:0] x,
    input  logic        y_tile,     // y[3]: checker row parity
    input  logic [7:0]  frame_cnt,  // low byte of the frame counter
    output logic [15:0] pix
);

    localparam int c_bar_w = H_ACTIVE / 8;

    logic [15:0] w_bar;
    logic [2:0]  w_bar_idx;
    logic [7:0]  w_grey;
    logic [7:0]  w_xs;

    always_comb begin
        w_bar     = x / 16'(c_bar_w);
        w_bar_idx = (w_bar > 16'd7) ? 3'd7 : w_bar[2:0];
        w_grey    = x[7:0];
        w_xs      = x[7:0] + frame_cnt;
        pix       = c_black;
        case (mode_q)
            c_mode_bars:   pix = bar_colour(w_bar_idx);
            c_mode_grey:   pix = {w_grey[7:3], w_grey[7:2], w_grey[7:3]};
            c_mode_check:  pix = (x[3] ^ y_tile) ? c_white : c_black;
            c_mode_scroll: pix = (w_xs[3] ^ y_tile) ? c_white : c_black;
            default:       pix = c_black;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dvp_pattern_tx.sv
`default_nettype none
// ============================================================================
//  Module   : dvp_pattern_tx
//  Brief    : OV5640-style DVP frame transmitter with built-in test patterns.
//  Revision : 1.0 - initial release
// ============================================================================
module dvp_pattern_tx
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE = 480,
    parameter int V_ACTIVE = 272,
    parameter int H_BLANK  = 64,
    parameter int VSYNC_W  = 2,
    parameter int V_BACK   = 4,
    parameter int V_FRONT  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [1:0]  mode,
    output logic        camera_vsync,
    output logic        camera_href,
    output logic [7:0]  camera_data,
    output logic        frame_start,
    output logic [15:0] frame_cnt,
    output logic        busy
);

    localparam int c_line_len = 2 * H_ACTIVE + H_BLANK;
    localparam int c_hw       = $clog2(c_line_len);
    localparam logic [c_hw-1:0] c_h_last = c_hw'(c_line_len - 1);
    localparam logic [c_hw-1:0] c_h_act  = c_hw'(2 * H_ACTIVE);

    dvp_state_t        r_state, w_state_nxt;
    logic [c_hw-1:0]   r_hcnt, w_hcnt_nxt;
    logic [15:0]       r_lcnt, w_lcnt_nxt;
    logic [1:0]        r_mode, w_mode_nxt;
    logic [15:0]       r_frame_cnt, w_frame_cnt_nxt;
    logic [15:0]       w_lines_last;
    logic              w_line_end;
    logic              w_start;
    logic              w_href;
    logic [15:0]       w_pix;
    logic [7:0]        w_byte;

    logic        r_vsync, r_href, r_frame_start, r_busy;
    logic [7:0]  r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_hcnt      <= '0;
            r_lcnt      <= '0;
            r_mode      <= c_mode_bars;
            r_frame_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_hcnt      <= w_hcnt_nxt;
            r_lcnt      <= w_lcnt_nxt;
            r_mode      <= w_mode_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
        end
    end

    always_comb begin
        w_line_end      = (r_hcnt == c_h_last);
        w_state_nxt     = r_state;
        w_hcnt_nxt      = r_hcnt;
        w_lcnt_nxt      = r_lcnt;
        w_mode_nxt      = r_mode;
        w_frame_cnt_nxt = r_frame_cnt;
        w_start         = 1'b0;
        case (r_state)
            ST_VSYNC:  w_lines_last = 16'(VSYNC_W - 1);
            ST_VBACK:  w_lines_last = 16'(V_BACK - 1);
            ST_ACTIVE: w_lines_last = 16'(V_ACTIVE - 1);
            ST_VFRONT: w_lines_last = 16'(V_FRONT - 1);
            default:   w_lines_last = '0;
        endcase

        if (r_state == ST_IDLE) begin
            w_hcnt_nxt = '0;
            w_lcnt_nxt = '0;
            w_start    = en;
        end else begin
            w_hcnt_nxt = w_line_end ? '0 : r_hcnt + 1'b1;
            if (w_line_end) begin
                if (r_lcnt == w_lines_last) begin
                    w_lcnt_nxt = '0;
                    case (r_state)
                        ST_VSYNC:  w_state_nxt = (V_BACK == 0) ? ST_ACTIVE : ST_VBACK;
                        ST_VBACK:  w_state_nxt = ST_ACTIVE;
                        ST_ACTIVE: w_state_nxt = ST_VFRONT;
                        ST_VFRONT: begin
                            w_state_nxt = ST_IDLE;
                            w_start     = en;
                        end
                        default:   w_state_nxt = ST_IDLE;
                    endcase
                end else begin
                    w_lcnt_nxt = r_lcnt + 16'd1;
                end
            end
        end

        // A new frame may begin from IDLE or straight out of VFRONT.
        if (w_start) begin
            w_state_nxt     = ST_VSYNC;
            w_mode_nxt      = mode;
            w_frame_cnt_nxt = r_frame_cnt + 16'd1;
        end
    end

    assign w_href = (r_state == ST_ACTIVE) && (r_hcnt < c_h_act);

    dvp_pattern_gen #(
        .H_ACTIVE (H_ACTIVE)
    ) u_gen (
        .mode_q    (r_mode),
        .x         (16'(r_hcnt >> 1)),
        .y_tile    (r_lcnt[3]),
        .frame_cnt (r_frame_cnt[7:0]),
        .pix       (w_pix)
    );

    // High byte on even clocks of each pixel pair, low byte on odd.
    assign w_byte = r_hcnt[0] ? w_pix[7:0] : w_pix[15:8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync       <= 1'b0;
            r_href        <= 1'b0;
            r_data        <= 8'h00;
            r_frame_start <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_vsync       <= (r_state == ST_VSYNC);
            r_href        <= w_href;
            r_data        <= w_href ? w_byte : 8'h00;
            r_frame_start <= (r_state == ST_VSYNC) && (r_lcnt == 16'd0) && (r_hcnt == '0);
            r_busy        <= (r_state != ST_IDLE);
        end
    end

    assign camera_vsync = r_vsync;
    assign camera_href  = r_href;
    assign camera_data  = r_data;
    assign frame_start  = r_frame_start;
    assign frame_cnt    = r_frame_cnt;
    assign busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_dvp_pattern_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dvp_pattern_tx
//  Brief    : Self-checking bench for dvp_pattern_tx with a pixel scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dvp_pattern_tx;

    localparam int A_H = 16;
    localparam int B_H = 32;
    localparam int HB  = 4;
    localparam int A_V = 4;
    localparam int B_V = 16;

    logic       clk;
    logic       rst_n;
    logic       en_a, en_b, sel;
    logic [1:0] mode_a, mode_b;

    logic        a_vsync, a_href, a_frame_start, a_busy;
    logic [7:0]  a_data;
    logic [15:0] a_frame_cnt;
    logic        b_vsync, b_href, b_frame_start, b_busy;
    logic [7:0]  b_data;
    logic [15:0] b_frame_cnt;

    dvp_pattern_tx #(
        .H_ACTIVE(A_H), .V_ACTIVE(A_V), .H_BLANK(HB),
        .VSYNC_W(1), .V_BACK(1), .V_FRONT(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .mode(mode_a),
        .camera_vsync(a_vsync), .camera_href(a_href), .camera_data(a_data),
        .frame_start(a_frame_start), .frame_cnt(a_frame_cnt), .busy(a_busy)
    );

    dvp_pattern_tx #(
        .H_ACTIVE(B_H), .V_ACTIVE(B_V), .H_BLANK(HB),
        .VSYNC_W(1), .V_BACK(1), .V_FRONT(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .mode(mode_b),
        .camera_vsync(b_vsync), .camera_href(b_href), .camera_data(b_data),
        .frame_start(b_frame_start), .frame_cnt(b_frame_cnt), .busy(b_busy)
    );

    // The monitor watches whichever instance sel points at.
    wire        m_vsync       = sel ? b_vsync       : a_vsync;
    wire        m_href        = sel ? b_href        : a_href;
    wire [7:0]  m_data        = sel ? b_data        : a_data;
    wire        m_frame_start = sel ? b_frame_start : a_frame_start;
    wire        m_busy        = sel ? b_busy        : a_busy;
    wire [15:0] m_frame_cnt   = sel ? b_frame_cnt   : a_frame_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] sb_q[$];
    logic [15:0] cap [0:15][0:31];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_pix(input int ha, input int md, input int x,
                                              input int y, input int fc);
        logic [15:0] bars [0:7];
        logic [7:0]  g;
        int          xs;
        bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
        g  = x[7:0];
        xs = (x + fc) % 256;
        case (md)
            0:       return bars[x / (ha / 8)];
            1:       return {g[7:3], g[7:2], g[7:3]};
            2:       return ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 16'hFFFF : 16'h0000;
            default: return ((((xs >> 3) ^ (y >> 3)) & 1) != 0) ? 16'hFFFF : 16'h0000;
        endcase
    endfunction

    task automatic push_frame(input int ha, input int va, input int md, input int fc);
        for (int y = 0; y < va; y++)
            for (int x = 0; x < ha; x++)
                sb_q.push_back(model_pix(ha, md, x, y, fc));
    endtask

    task automatic wait_fs(input string tag);
        for (int i = 0; i < 600; i++) begin
            if (m_frame_start) break;
            @(negedge clk);
        end
        check(tag, 32'(m_frame_start), 32'd1);
    endtask

    // Entered on the cycle frame_start is seen; returns one frame period later.
    task automatic run_frame(input int ha, input int va, input int chg_t,
                             input logic new_en, input logic [1:0] new_mode,
                             input logic exp_next);
        int          ll, period, first, hi_cnt, rises, run, gap, bad_low, vs_cnt;
        logic        prev;
        logic [7:0]  hb;
        logic [15:0] e;
        ll = 2 * ha + HB;
        period = (3 + va) * ll;
        first = -1; hi_cnt = 0; rises = 0; run = 0; gap = 0; bad_low = 0; vs_cnt = 0;
        prev = 1'b0; hb = 8'h00;
        for (int t = 0; t < period; t++) begin
            if (m_vsync) vs_cnt++;
            if (m_href) begin
                if (!prev) begin
                    rises++;
                    if (first < 0) first = t;
                    else check("hblank_gap", 32'(gap), 32'(HB));
                    run = 0;
                end
                if (run[0] == 1'b0) begin
                    hb = m_data;
                end else begin
                    e = 'x;
                    if (sb_q.size() > 0) e = sb_q.pop_front();
                    check("pixel", 32'({hb, m_data}), 32'(e));
                    if (rises - 1 < 16 && (run >> 1) < 32)
                        cap[rises - 1][run >> 1] = {hb, m_data};
                end
                run++;
                hi_cnt++;
            end else begin
                if (prev) begin
                    check("href_len", 32'(run), 32'(2 * ha));
                    gap = 0;
                end
                gap++;
                if (m_data !== 8'h00) bad_low++;
            end
            prev = m_href;
            if (t == chg_t) begin
                if (sel) begin en_b = new_en; mode_b = new_mode; end
                else     begin en_a = new_en; mode_a = new_mode; end
            end
            @(negedge clk);
        end
        check("first_href", 32'(first), 32'(2 * ll));
        check("href_pulses", 32'(rises), 32'(va));
        check("href_total", 32'(hi_cnt), 32'(va * 2 * ha));
        check("data_low_zero", 32'(bad_low), 32'd0);
        check("vsync_len", 32'(vs_cnt), 32'(ll));
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        check("period_fs", 32'(m_frame_start), 32'(exp_next));
        check("period_busy", 32'(m_busy), 32'(exp_next));
    endtask

    initial begin
        int hi;
        rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; mode_a = 2'd0; mode_b = 2'd0; sel = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_a", 32'({a_vsync, a_href, a_data, a_frame_start, a_busy, a_frame_cnt}), 32'd0);
        check("reset_b", 32'({b_vsync, b_href, b_data, b_frame_start, b_busy, b_frame_cnt}), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle", 32'({m_vsync, m_href, m_data, m_frame_start, m_busy, m_frame_cnt}), 32'd0);
        end

        // Bars, with mode switched to grey mid-frame for the next frame.
        push_frame(A_H, A_V, 0, 1);
        en_a = 1'b1; mode_a = 2'd0;
        @(negedge clk);
        check("fs_n1", 32'(m_frame_start), 32'd0);
        @(negedge clk);
        check("fs_n2", 32'({m_frame_start, m_vsync, m_busy}), 32'b111);
        check("cnt_f1", 32'(m_frame_cnt), 32'd1);
        run_frame(A_H, A_V, 100, 1'b1, 2'd1, 1'b1);

        // Grey frame; en dropped and mode changed mid-frame must not cut it short.
        push_frame(A_H, A_V, 1, 2);
        check("cnt_f2", 32'(m_frame_cnt), 32'd2);
        run_frame(A_H, A_V, 100, 1'b0, 2'd2, 1'b0);
        check("cnt_hold", 32'(m_frame_cnt), 32'd2);
        repeat (20) @(negedge clk);
        check("idle_after", 32'({m_busy, m_vsync, m_href, m_frame_start}), 32'd0);

        // Checkerboard then scrolling checker on the wider instance.
        sel = 1'b1;
        push_frame(B_H, B_V, 2, 1);
        en_b = 1'b1; mode_b = 2'd2;
        wait_fs("fs_b1");
        check("cnt_b1", 32'(m_frame_cnt), 32'd1);
        run_frame(B_H, B_V, 500, 1'b1, 2'd3, 1'b1);
        check("chk_8_0", 32'(cap[0][8]), 32'hFFFF);
        check("chk_0_0", 32'(cap[0][0]), 32'h0000);
        check("chk_8_8", 32'(cap[8][8]), 32'h0000);
        push_frame(B_H, B_V, 3, 2);
        check("cnt_b2", 32'(m_frame_cnt), 32'd2);
        run_frame(B_H, B_V, 500, 1'b0, 2'd3, 1'b0);
        check("scroll_6_0", 32'(cap[0][6]), 32'hFFFF);
        check("scroll_14_0", 32'(cap[0][14]), 32'h0000);
        check("scroll_0_8", 32'(cap[8][0]), 32'hFFFF);

        // Counter wrap, then reset in the middle of an href pulse.
        sel = 1'b0;
        force dut_a.r_frame_cnt = 16'hFFFF;
        @(negedge clk);
        release dut_a.r_frame_cnt;
        @(negedge clk);
        check("preload", 32'(m_frame_cnt), 32'hFFFF);
        en_a = 1'b1; mode_a = 2'd0;
        wait_fs("fs_wrap");
        check("wrap", 32'(m_frame_cnt), 32'h0000);
        en_a = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (m_href) break;
            @(negedge clk);
        end
        repeat (5) @(negedge clk);
        check("href_pre_rst", 32'(m_href), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_drop", 32'({m_href, m_data, m_vsync, m_busy, m_frame_start, m_frame_cnt}), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        hi = 0;
        repeat (300) begin
            @(negedge clk);
            if (m_href || m_busy || m_vsync) hi++;
        end
        check("no_resume", 32'(hi), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
